telemetry_tx: RTL and testbench

//  Telemetry source inside eBike: periodically snapshots batt/curr/torque and sends them as an 8-byte framed packet on serial TX line.

---
 rtl/telemetry_tx.sv | 102 ++++++++++
 tb/tb_telemetry_tx.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/telemetry_tx.sv
// telemetry_tx: periodic 8-byte telemetry packet (AA 55 batt curr torque) sent as 8N1 UART, LSB first.
module telemetry_tx #(
  parameter int BAUD_DIV = 2604,
  parameter int PERIOD =
`ifdef FAST_SIM
    4096
`else
    1048576
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] batt,
  input  logic [11:0] curr,
  input  logic [11:0] torque,
  output logic        TX,
  output logic        busy,
  output logic        pkt_done
);
  localparam int BW = $clog2(BAUD_DIV);
  localparam int PW = $clog2(PERIOD);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  state_e        state_q;
  logic [PW-1:0] period_cnt_q;
  logic [BW-1:0] baud_cnt_q;
  logic          pending_q;
  logic [2:0]    byte_idx_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic [35:0]   snap_q;
  logic          tx_q;
  logic          busy_q;
  logic          pkt_done_q;
  logic          tick;
  logic          baud_end;
  assign tick     = period_cnt_q == PW'(PERIOD - 1);
  assign baud_end = baud_cnt_q == BW'(BAUD_DIV - 1);
  assign TX       = tx_q;
  assign busy     = busy_q;
  assign pkt_done = pkt_done_q;
  // Byte i of the frame, drawn from the snapshot {batt, curr, torque}.
  function automatic logic [7:0] pkt_byte(input logic [2:0] i, input logic [35:0] s);
    logic [11:0] f;
    f = i[2:1] == 2'd1 ? s[35:24] : i[2:1] == 2'd2 ? s[23:12] : s[11:0];
    return i < 3'd2 ? (i[0] ? 8'h55 : 8'hAA) : i[0] ? f[7:0] : {4'h0, f[11:8]};
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      period_cnt_q <= '0;
      baud_cnt_q   <= '0;
      pending_q    <= 1'b0;
      byte_idx_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      snap_q       <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      pkt_done_q   <= 1'b0;
    end else begin
      period_cnt_q <= tick ? '0 : period_cnt_q + 1'b1;
      baud_cnt_q   <= (state_q == IDLE || baud_end) ? '0 : baud_cnt_q + 1'b1;
      pkt_done_q   <= 1'b0;
      if (tick && en) pending_q <= 1'b1;
      case (state_q)
        IDLE: if (pending_q) begin
          pending_q  <= 1'b0;
          snap_q     <= {batt, curr, torque};
          byte_idx_q <= '0;
          shift_q    <= 8'hAA;
          state_q    <= START;
          tx_q       <= 1'b0;
          busy_q     <= 1'b1;
        end
        START: if (baud_end) begin
          state_q   <= DATA;
          bit_cnt_q <= '0;
          tx_q      <= shift_q[0];
        end
        DATA: if (baud_end) begin
          shift_q   <= shift_q >> 1;
          bit_cnt_q <= bit_cnt_q + 1'b1;
          state_q   <= bit_cnt_q == 3'd7 ? STOP : DATA;
          tx_q      <= bit_cnt_q == 3'd7 || shift_q[1];
        end
        STOP: if (baud_end) begin
          if (byte_idx_q != 3'd7) begin
            byte_idx_q <= byte_idx_q + 1'b1;
            shift_q    <= pkt_byte(byte_idx_q + 1'b1, snap_q);
            state_q    <= START;
            tx_q       <= 1'b0;
          end else begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            pkt_done_q <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_telemetry_tx.sv
// tb_telemetry_tx: drives two telemetry_tx instances (PERIOD 400 and 200) and decodes TX against a packet model.
module tb_telemetry_tx;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, sel = 1'b0;
  logic [11:0] batt = '0, curr = '0, torque = '0;
  logic tx1, busy1, done1, tx2, busy2, done2;
  logic tx_s, busy_s, done_s;
  int cyc = 0, passed = 0, total = 0, fails = 0, prev = 0;
  telemetry_tx #(.BAUD_DIV(4), .PERIOD(400)) dut1 (
    .clk(clk), .rst(rst), .en(en), .batt(batt), .curr(curr), .torque(torque),
    .TX(tx1), .busy(busy1), .pkt_done(done1));
  telemetry_tx #(.BAUD_DIV(4), .PERIOD(200)) dut2 (
    .clk(clk), .rst(rst), .en(en), .batt(batt), .curr(curr), .torque(torque),
    .TX(tx2), .busy(busy2), .pkt_done(done2));
  always #5 clk = ~clk;
  assign tx_s   = sel ? tx2 : tx1;
  assign busy_s = sel ? busy2 : busy1;
  assign done_s = sel ? done2 : done1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
  endtask
  task automatic rand_inputs();
    batt   = 12'($urandom);
    curr   = 12'($urandom);
    torque = 12'($urandom);
  endtask
  // Frame contents: two sync bytes, then each 12-bit field zero-extended to 16 bits, high byte first.
  function automatic logic [63:0] model(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
    return (64'hAA55 << 48) | (64'(b) << 32) | (64'(c) << 16) | 64'(t);
  endfunction
  task automatic wait_fall(input int bound);
    int n = 0;
    while (tx_s !== 1'b0 && n < bound) begin
      step();
      n++;
    end
    chk("start_timeout", 64'(n < bound), 64'(1));
  endtask
  task automatic quiet(input int n, input string tag);
    int bad = 0;
    repeat (n) begin
      step();
      if (tx_s !== 1'b1 || busy_s !== 1'b0 || done_s !== 1'b0) bad++;
    end
    chk(tag, 64'(bad), 64'(0));
  endtask
  // Called on the first start-bit cycle; samples every clock of all 80 bit slots.
  task automatic recv(input int chg_at, input int drop_at, input int rst_at);
    logic [63:0] exp, rx;
    logic [7:0] cur;
    logic [3:0] s4;
    int bit_err = 0, frame_err = 0, ctl_err = 0, p;
    exp = model(batt, curr, torque);
    rx  = '0;
    cur = '0;
    for (int j = 0; j < 80; j++) begin
      for (int k = 0; k < 4; k++) begin
        if (4 * j + k == rst_at) begin
          rst = 1'b1;
          step();
          chk("rst_midpacket", {tx_s, busy_s, done_s}, 3'b100);
          rst = 1'b0;
          cyc = 0;
          return;
        end
        if (4 * j + k == chg_at) rand_inputs();
        if (4 * j + k == drop_at) en = 1'b0;
        s4[k] = tx_s;
        if (busy_s !== 1'b1 || done_s !== 1'b0) ctl_err++;
        step();
      end
      if (s4 !== 4'h0 && s4 !== 4'hF) bit_err++;
      p = j % 10;
      if (p == 0) begin
        if (s4[0] !== 1'b0) frame_err++;
      end else if (p == 9) begin
        if (s4[0] !== 1'b1) frame_err++;
        rx = {rx[55:0], cur};
      end else cur[p-1] = s4[0];
    end
    chk("bit_stable", 64'(bit_err), 64'(0));
    chk("framing", 64'(frame_err), 64'(0));
    chk("busy_during_pkt", 64'(ctl_err), 64'(0));
    chk("packet_bytes", rx, exp);
    chk("end_state", {tx_s, busy_s, done_s}, 3'b101);
  endtask
  initial begin
    sel = 1'b0;
    en = 1'b1;
    batt = 12'hABC;
    curr = 12'h123;
    torque = 12'h7F0;
    do_reset();
    chk("reset_state", {tx1, busy1, done1, tx2, busy2, done2}, 6'b100100);
    wait_fall(1000);
    chk("first_start", 64'(cyc), 64'(401));
    prev = cyc;
    recv(44, -1, -1);
    for (int i = 1; i < 5; i++) begin
      wait_fall(1000);
      chk("start_period400", 64'(cyc), 64'(prev + 400));
      prev = cyc;
      recv(int'($urandom_range(0, 319)), -1, -1);
    end
    sel = 1'b1;
    do_reset();
    rand_inputs();
    wait_fall(1000);
    chk("first_start_p200", 64'(cyc), 64'(201));
    prev = cyc;
    recv(int'($urandom_range(0, 319)), -1, -1);
    for (int i = 1; i < 4; i++) begin
      wait_fall(1000);
      chk("backtoback_gap", 64'(cyc - prev), 64'(321));
      prev = cyc;
      recv(int'($urandom_range(0, 319)), i == 2 ? 250 : -1, -1);
    end
    quiet(700, "quiet_after_pending");
    sel = 1'b0;
    en = 1'b0;
    do_reset();
    quiet(1000, "en_low_quiet");
    en = 1'b1;
    wait_fall(1000);
    chk("start_after_en", 64'(cyc), 64'(1201));
    recv(-1, 100, -1);
    quiet(1200, "quiet_after_en_drop");
    en = 1'b1;
    do_reset();
    rand_inputs();
    wait_fall(1000);
    chk("start_before_rst", 64'(cyc), 64'(401));
    recv(-1, -1, 178);
    rand_inputs();
    wait_fall(1000);
    chk("start_after_rst", 64'(cyc), 64'(401));
    recv(-1, -1, -1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
